// File: rtl/ibuf_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ibuf_fetch_ctrl
//
// Fetch sequencer for the four-slot instruction buffer in the F stage.
// It tracks which of the four 16-byte line slots hold valid, in-order fetch
// lines. Each cycle it issues up to two line requests, split across the even
// and odd I-cache banks, and raises per-slot load strobes on hits. It parks
// on a miss until the fill completes. A resteer flushes the buffer and
// re-targets fetch. Decode frees lines oldest-first.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high; returns to IDLE and clears all state
//   resteer          pulse: flush the buffer and restart fetch at resteer_addr
//   resteer_addr     new fetch byte address (bits [3:0] are not used)
//   line_release     decode has consumed the oldest valid line
//   icache_req_e     request to the even bank
//   icache_addr_e    even-bank line address
//   icache_req_o     request to the odd bank
//   icache_addr_o    odd-bank line address
//   icache_hit_e     even-bank hit, in the same cycle as the request
//   icache_hit_o     odd-bank hit, in the same cycle as the request
//   icache_fill_done pulse: the outstanding miss has been filled
//   slot_ld          per-slot load strobe to the buffer data registers
//   slot_valid       registered per-slot valid bits
//   head_slot        slot that holds the oldest valid line
//   fetch_stall      high while the sequencer is in MISS or IDLE
// ---------------------------------------------------------------------------
module ibuf_fetch_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resteer,
    input  logic [ADDR_W-1:0] resteer_addr,
    input  logic              line_release,
    output logic              icache_req_e,
    output logic [ADDR_W-5:0] icache_addr_e,
    output logic              icache_req_o,
    output logic [ADDR_W-5:0] icache_addr_o,
    input  logic              icache_hit_e,
    input  logic              icache_hit_o,
    input  logic              icache_fill_done,
    output logic [3:0]        slot_ld,
    output logic [3:0]        slot_valid,
    output logic [1:0]        head_slot,
    output logic              fetch_stall
);

    localparam int LINE_W = ADDR_W - 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_MISS  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // One-hot slot mask, gated by an enable.
    function automatic logic [3:0] slot_mask(input logic [1:0] slot, input logic en);
        logic [3:0] m;
        if (en) begin
            m = 4'b0001 << slot;
        end else begin
            m = 4'b0000;
        end
        return m;
    endfunction

    // Architectural state
    state_t              state_r;
    logic [LINE_W-1:0]   flp_r;     // next line to fetch
    logic [1:0]          head_r;    // slot of the oldest valid line
    logic [2:0]          occ_r;     // occupancy, 0..4
    logic [3:0]          valid_r;

    // Next-state values
    state_t              state_nxt_s;
    logic [LINE_W-1:0]   flp_nxt_s;
    logic [1:0]          head_nxt_s;
    logic [2:0]          occ_nxt_s;
    logic [3:0]          valid_nxt_s;

    // Request / outcome decode
    logic [LINE_W-1:0]   line_a_s;
    logic [LINE_W-1:0]   line_b_s;
    logic                a_even_s;
    logic                req_a_s;
    logic                req_b_s;
    logic                hit_a_s;
    logic                hit_b_s;
    logic                ld_a_s;
    logic                ld_b_s;
    logic                rel_s;
    logic [3:0]          slot_ld_s;

    // The low byte-offset bits of the resteer address carry no meaning here.
    logic                unused_addr_bits_s;
    assign unused_addr_bits_s = ^resteer_addr[3:0];

    // Candidate lines A/B and their steering onto the even/odd banks.
    always_comb begin
        line_a_s = flp_r;
        line_b_s = flp_r + {{(LINE_W-1){1'b0}}, 1'b1};
        a_even_s = ~flp_r[0];
        req_a_s  = 1'b0;
        req_b_s  = 1'b0;
        if (state_r == ST_RUN) begin
            req_a_s = (occ_r < 3'd4);
            req_b_s = (occ_r < 3'd3);
        end else begin
            req_a_s = 1'b0;
            req_b_s = 1'b0;
        end
        // A and B are consecutive lines, so they always land on opposite banks.
        if (a_even_s) begin
            icache_req_e  = req_a_s;
            icache_addr_e = line_a_s;
            icache_req_o  = req_b_s;
            icache_addr_o = line_b_s;
            hit_a_s       = icache_hit_e;
            hit_b_s       = icache_hit_o;
        end else begin
            icache_req_e  = req_b_s;
            icache_addr_e = line_b_s;
            icache_req_o  = req_a_s;
            icache_addr_o = line_a_s;
            hit_a_s       = icache_hit_o;
            hit_b_s       = icache_hit_e;
        end
    end

    // Hit/miss outcome, FSM next state, and pointer/occupancy/valid updates.
    always_comb begin
        state_nxt_s = state_r;
        flp_nxt_s   = flp_r;
        head_nxt_s  = head_r;
        occ_nxt_s   = occ_r;
        valid_nxt_s = valid_r;
        ld_a_s      = 1'b0;
        ld_b_s      = 1'b0;
        rel_s       = 1'b0;
        slot_ld_s   = 4'b0000;

        if (resteer) begin
            // Resteer overrides loads, releases and any pending miss.
            state_nxt_s = ST_FLUSH;
            flp_nxt_s   = resteer_addr[ADDR_W-1:4];
            head_nxt_s  = resteer_addr[5:4];
            occ_nxt_s   = 3'd0;
            valid_nxt_s = 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (req_a_s) begin
                        if (hit_a_s) begin
                            ld_a_s = 1'b1;
                            if (req_b_s) begin
                                if (hit_b_s) begin
                                    ld_b_s = 1'b1;
                                end else begin
                                    state_nxt_s = ST_MISS;
                                end
                            end else begin
                                ld_b_s = 1'b0;
                            end
                        end else begin
                            // A B hit behind a missing A would load out of order.
                            state_nxt_s = ST_MISS;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_MISS: begin
                    if (icache_fill_done) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_MISS;
                    end
                end
                ST_FLUSH: begin
                    state_nxt_s = ST_RUN;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase

            rel_s       = line_release && (occ_r != 3'd0);
            slot_ld_s   = slot_mask(line_a_s[1:0], ld_a_s) | slot_mask(line_b_s[1:0], ld_b_s);
            flp_nxt_s   = flp_r + {{(LINE_W-1){1'b0}}, ld_a_s} + {{(LINE_W-1){1'b0}}, ld_b_s};
            head_nxt_s  = head_r + {1'b0, rel_s};
            occ_nxt_s   = occ_r + {2'b00, ld_a_s} + {2'b00, ld_b_s} - {2'b00, rel_s};
            // Loads target free slots only, so they never collide with the released head.
            valid_nxt_s = (valid_r & ~slot_mask(head_r, rel_s)) | slot_ld_s;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            flp_r   <= {LINE_W{1'b0}};
            head_r  <= 2'd0;
            occ_r   <= 3'd0;
            valid_r <= 4'b0000;
        end else begin
            state_r <= state_nxt_s;
            flp_r   <= flp_nxt_s;
            head_r  <= head_nxt_s;
            occ_r   <= occ_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign slot_ld     = slot_ld_s;
    assign slot_valid  = valid_r;
    assign head_slot   = head_r;
    assign fetch_stall = (state_r == ST_MISS) || (state_r == ST_IDLE);

endmodule

// File: tb/tb_ibuf_fetch_ctrl.sv
module tb_ibuf_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        resteer;
    logic [31:0] resteer_addr;
    logic        line_release;
    logic        icache_req_e;
    logic [27:0] icache_addr_e;
    logic        icache_req_o;
    logic [27:0] icache_addr_o;
    logic        icache_hit_e;
    logic        icache_hit_o;
    logic        icache_fill_done;
    logic [3:0]  slot_ld;
    logic [3:0]  slot_valid;
    logic [1:0]  head_slot;
    logic        fetch_stall;

    int n_checks;
    int n_fail;

    ibuf_fetch_ctrl #(.ADDR_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .resteer          (resteer),
        .resteer_addr     (resteer_addr),
        .line_release     (line_release),
        .icache_req_e     (icache_req_e),
        .icache_addr_e    (icache_addr_e),
        .icache_req_o     (icache_req_o),
        .icache_addr_o    (icache_addr_o),
        .icache_hit_e     (icache_hit_e),
        .icache_hit_o     (icache_hit_o),
        .icache_fill_done (icache_fill_done),
        .slot_ld          (slot_ld),
        .slot_valid       (slot_valid),
        .head_slot        (head_slot),
        .fetch_stall      (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_resteer(input logic [31:0] a);
        resteer      = 1'b1;
        resteer_addr = a;
        cyc();
        resteer      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        n_checks++; if (slot_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", slot_valid); end
        n_checks++; if (head_slot !== 2'd0) begin n_fail++; $display("FAIL reset_head: got %0d want 0", head_slot); end
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", fetch_stall); end
        n_checks++; if ({icache_req_e, icache_req_o} !== 2'b00) begin n_fail++; $display("FAIL reset_req: got %b want 00", {icache_req_e, icache_req_o}); end
        n_checks++; if (slot_ld !== 4'b0000) begin n_fail++; $display("FAIL reset_ld: got %b want 0000", slot_ld); end
        cyc();
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL idle_stays: got %b want 1", fetch_stall); end
    endtask

    task automatic test_aligned_fetch();
        icache_hit_e = 1'b1;
        icache_hit_o = 1'b1;
        do_resteer(32'h0000_1000);
        // FLUSH cycle
        n_checks++; if ({icache_req_e, icache_req_o} !== 2'b00) begin n_fail++; $display("FAIL al_flush_req: got %b want 00", {icache_req_e, icache_req_o}); end
        n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL al_flush_stall: got %b want 0", fetch_stall); end
        cyc();
        n_checks++; if ({icache_req_e, icache_addr_e} !== {1'b1, 28'h100}) begin n_fail++; $display("FAIL al_c2_even: got %b/%h want 1/100", icache_req_e, icache_addr_e); end
        n_checks++; if ({icache_req_o, icache_addr_o} !== {1'b1, 28'h101}) begin n_fail++; $display("FAIL al_c2_odd: got %b/%h want 1/101", icache_req_o, icache_addr_o); end
        n_checks++; if (slot_ld !== 4'b0011) begin n_fail++; $display("FAIL al_c2_ld: got %b want 0011", slot_ld); end
        cyc();
        n_checks++; if (slot_valid !== 4'b0011) begin n_fail++; $display("FAIL al_c3_valid: got %b want 0011", slot_valid); end
        n_checks++; if ({icache_req_e, icache_addr_e} !== {1'b1, 28'h102}) begin n_fail++; $display("FAIL al_c3_even: got %b/%h want 1/102", icache_req_e, icache_addr_e); end
        n_checks++; if ({icache_req_o, icache_addr_o} !== {1'b1, 28'h103}) begin n_fail++; $display("FAIL al_c3_odd: got %b/%h want 1/103", icache_req_o, icache_addr_o); end
        n_checks++; if (slot_ld !== 4'b1100) begin n_fail++; $display("FAIL al_c3_ld: got %b want 1100", slot_ld); end
        cyc();
        n_checks++; if (slot_valid !== 4'b1111) begin n_fail++; $display("FAIL al_full_valid: got %b want 1111", slot_valid); end
        n_checks++; if ({icache_req_e, icache_req_o} !== 2'b00) begin n_fail++; $display("FAIL al_full_req: got %b want 00", {icache_req_e, icache_req_o}); end
        n_checks++; if (slot_ld !== 4'b0000) begin n_fail++; $display("FAIL al_full_ld: got %b want 0000", slot_ld); end
        n_checks++; if (head_slot !== 2'd0) begin n_fail++; $display("FAIL al_head: got %0d want 0", head_slot); end
    endtask

    task automatic test_odd_start();
        icache_hit_e = 1'b1;
        icache_hit_o = 1'b1;
        do_resteer(32'h0000_1030);
        n_checks++; if (slot_valid !== 4'b0000) begin n_fail++; $display("FAIL odd_flush_valid: got %b want 0000", slot_valid); end
        n_checks++; if (head_slot !== 2'd3) begin n_fail++; $display("FAIL odd_head: got %0d want 3", head_slot); end
        cyc();
        n_checks++; if ({icache_req_o, icache_addr_o} !== {1'b1, 28'h103}) begin n_fail++; $display("FAIL odd_a: got %b/%h want 1/103", icache_req_o, icache_addr_o); end
        n_checks++; if ({icache_req_e, icache_addr_e} !== {1'b1, 28'h104}) begin n_fail++; $display("FAIL odd_b: got %b/%h want 1/104", icache_req_e, icache_addr_e); end
        n_checks++; if (slot_ld !== 4'b1001) begin n_fail++; $display("FAIL odd_ld: got %b want 1001", slot_ld); end
        cyc();
        n_checks++; if (slot_valid !== 4'b1001) begin n_fail++; $display("FAIL odd_valid: got %b want 1001", slot_valid); end
        n_checks++; if (slot_ld !== 4'b0110) begin n_fail++; $display("FAIL odd_ld2: got %b want 0110", slot_ld); end
        cyc();
        n_checks++; if (slot_valid !== 4'b1111) begin n_fail++; $display("FAIL odd_valid2: got %b want 1111", slot_valid); end
    endtask

    task automatic test_wrap();
        icache_hit_e = 1'b1;
        icache_hit_o = 1'b1;
        do_resteer(32'hFFFF_FFF0);
        n_checks++; if (head_slot !== 2'd3) begin n_fail++; $display("FAIL wrap_head: got %0d want 3", head_slot); end
        cyc();
        n_checks++; if ({icache_req_o, icache_addr_o} !== {1'b1, 28'hFFF_FFFF}) begin n_fail++; $display("FAIL wrap_a: got %b/%h want 1/fffffff", icache_req_o, icache_addr_o); end
        n_checks++; if ({icache_req_e, icache_addr_e} !== {1'b1, 28'h000_0000}) begin n_fail++; $display("FAIL wrap_b: got %b/%h want 1/0000000", icache_req_e, icache_addr_e); end
        n_checks++; if (slot_ld !== 4'b1001) begin n_fail++; $display("FAIL wrap_ld: got %b want 1001", slot_ld); end
        cyc();
        n_checks++; if ({icache_req_o, icache_addr_o} !== {1'b1, 28'h000_0001}) begin n_fail++; $display("FAIL wrap_a2: got %b/%h want 1/0000001", icache_req_o, icache_addr_o); end
        n_checks++; if ({icache_req_e, icache_addr_e} !== {1'b1, 28'h000_0002}) begin n_fail++; $display("FAIL wrap_b2: got %b/%h want 1/0000002", icache_req_e, icache_addr_e); end
        n_checks++; if (slot_ld !== 4'b0110) begin n_fail++; $display("FAIL wrap_ld2: got %b want 0110", slot_ld); end
    endtask

    task automatic test_a_hit_b_miss();
        icache_hit_e = 1'b1;
        icache_hit_o = 1'b0;
        do_resteer(32'h0000_2000);
        cyc();
        n_checks++; if (slot_ld !== 4'b0001) begin n_fail++; $display("FAIL ahbm_ld: got %b want 0001", slot_ld); end
        cyc();
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL ahbm_stall: got %b want 1", fetch_stall); end
        n_checks++; if (slot_valid !== 4'b0001) begin n_fail++; $display("FAIL ahbm_valid: got %b want 0001", slot_valid); end
        n_checks++; if ({icache_req_e, icache_req_o} !== 2'b00) begin n_fail++; $display("FAIL ahbm_miss_req: got %b want 00", {icache_req_e, icache_req_o}); end
        cyc();
        icache_fill_done = 1'b1;
        #1;
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL ahbm_fill_stall: got %b want 1", fetch_stall); end
        cyc();
        icache_fill_done = 1'b0;
        icache_hit_o = 1'b1;
        #1;
        n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL ahbm_run_stall: got %b want 0", fetch_stall); end
        n_checks++; if ({icache_req_o, icache_addr_o} !== {1'b1, 28'h201}) begin n_fail++; $display("FAIL ahbm_rereq: got %b/%h want 1/201", icache_req_o, icache_addr_o); end
        n_checks++; if ({icache_req_e, icache_addr_e} !== {1'b1, 28'h202}) begin n_fail++; $display("FAIL ahbm_rereq_b: got %b/%h want 1/202", icache_req_e, icache_addr_e); end
        n_checks++; if (slot_ld !== 4'b0110) begin n_fail++; $display("FAIL ahbm_reld: got %b want 0110", slot_ld); end
        cyc();
        n_checks++; if (slot_valid !== 4'b0111) begin n_fail++; $display("FAIL ahbm_valid2: got %b want 0111", slot_valid); end
        n_checks++; if ({icache_req_o, icache_addr_o, icache_req_e} !== {1'b1, 28'h203, 1'b0}) begin n_fail++; $display("FAIL ahbm_one_req: got %b/%h/%b want 1/203/0", icache_req_o, icache_addr_o, icache_req_e); end
        n_checks++; if (slot_ld !== 4'b1000) begin n_fail++; $display("FAIL ahbm_ld3: got %b want 1000", slot_ld); end
    endtask

    task automatic test_a_miss_b_hit();
        icache_hit_e = 1'b0;
        icache_hit_o = 1'b1;
        do_resteer(32'h0000_3000);
        cyc();
        n_checks++; if (slot_ld !== 4'b0000) begin n_fail++; $display("FAIL ambh_ld: got %b want 0000", slot_ld); end
        cyc();
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL ambh_stall: got %b want 1", fetch_stall); end
        n_checks++; if (slot_valid !== 4'b0000) begin n_fail++; $display("FAIL ambh_valid: got %b want 0000", slot_valid); end
        icache_fill_done = 1'b1;
        cyc();
        icache_fill_done = 1'b0;
        icache_hit_e = 1'b1;
        #1;
        n_checks++; if ({icache_req_e, icache_addr_e} !== {1'b1, 28'h300}) begin n_fail++; $display("FAIL ambh_retry: got %b/%h want 1/300", icache_req_e, icache_addr_e); end
        n_checks++; if (slot_ld !== 4'b0011) begin n_fail++; $display("FAIL ambh_ld2: got %b want 0011", slot_ld); end
        cyc();
        n_checks++; if (slot_valid !== 4'b0011) begin n_fail++; $display("FAIL ambh_valid2: got %b want 0011", slot_valid); end
    endtask

    // Continues from test_a_miss_b_hit: lines 0x300/0x301 held, head 0.
    task automatic test_full_release();
        icache_hit_e = 1'b1;
        icache_hit_o = 1'b1;
        n_checks++; if (slot_ld !== 4'b1100) begin n_fail++; $display("FAIL fr_fill: got %b want 1100", slot_ld); end
        cyc();
        n_checks++; if ({icache_req_e, icache_req_o} !== 2'b00) begin n_fail++; $display("FAIL fr_full_req: got %b want 00", {icache_req_e, icache_req_o}); end
        line_release = 1'b1;
        cyc();
        line_release = 1'b0;
        #1;
        n_checks++; if (slot_valid !== 4'b1110) begin n_fail++; $display("FAIL fr_rel_valid: got %b want 1110", slot_valid); end
        n_checks++; if (head_slot !== 2'd1) begin n_fail++; $display("FAIL fr_rel_head: got %0d want 1", head_slot); end
        n_checks++; if ({icache_req_e, icache_addr_e, icache_req_o} !== {1'b1, 28'h304, 1'b0}) begin n_fail++; $display("FAIL fr_one_req: got %b/%h/%b want 1/304/0", icache_req_e, icache_addr_e, icache_req_o); end
        n_checks++; if (slot_ld !== 4'b0001) begin n_fail++; $display("FAIL fr_freed_ld: got %b want 0001", slot_ld); end
        cyc();
        n_checks++; if (slot_valid !== 4'b1111) begin n_fail++; $display("FAIL fr_refull: got %b want 1111", slot_valid); end
        line_release = 1'b1;
        cyc();
        #1;
        n_checks++; if ({icache_req_o, icache_addr_o, icache_req_e} !== {1'b1, 28'h305, 1'b0}) begin n_fail++; $display("FAIL fr_req2: got %b/%h/%b want 1/305/0", icache_req_o, icache_addr_o, icache_req_e); end
        n_checks++; if (slot_ld !== 4'b0010) begin n_fail++; $display("FAIL fr_ld2: got %b want 0010", slot_ld); end
        cyc();
        line_release = 1'b0;
        #1;
        n_checks++; if (slot_valid !== 4'b1011) begin n_fail++; $display("FAIL fr_ldrel_valid: got %b want 1011", slot_valid); end
        n_checks++; if (head_slot !== 2'd3) begin n_fail++; $display("FAIL fr_ldrel_head: got %0d want 3", head_slot); end
        n_checks++; if ({icache_req_e, icache_addr_e, icache_req_o} !== {1'b1, 28'h306, 1'b0}) begin n_fail++; $display("FAIL fr_occ3_req: got %b/%h/%b want 1/306/0", icache_req_e, icache_addr_e, icache_req_o); end
    endtask

    // Entered while a hit on line 0x306 is being offered.
    task automatic test_resteer_priority();
        resteer          = 1'b1;
        resteer_addr     = 32'h0000_4050;
        line_release     = 1'b1;
        icache_fill_done = 1'b1;
        #1;
        n_checks++; if (slot_ld !== 4'b0000) begin n_fail++; $display("FAIL rp_ld: got %b want 0000", slot_ld); end
        cyc();
        resteer          = 1'b0;
        line_release     = 1'b0;
        icache_fill_done = 1'b0;
        #1;
        n_checks++; if (slot_valid !== 4'b0000) begin n_fail++; $display("FAIL rp_valid: got %b want 0000", slot_valid); end
        n_checks++; if (head_slot !== 2'd1) begin n_fail++; $display("FAIL rp_head: got %0d want 1", head_slot); end
        n_checks++; if ({icache_req_e, icache_req_o, fetch_stall} !== 3'b000) begin n_fail++; $display("FAIL rp_flush: got %b want 000", {icache_req_e, icache_req_o, fetch_stall}); end
        cyc();
        n_checks++; if ({icache_req_o, icache_addr_o} !== {1'b1, 28'h405}) begin n_fail++; $display("FAIL rp_a: got %b/%h want 1/405", icache_req_o, icache_addr_o); end
        n_checks++; if ({icache_req_e, icache_addr_e} !== {1'b1, 28'h406}) begin n_fail++; $display("FAIL rp_b: got %b/%h want 1/406", icache_req_e, icache_addr_e); end
        n_checks++; if (slot_ld !== 4'b0110) begin n_fail++; $display("FAIL rp_ld2: got %b want 0110", slot_ld); end
    endtask

    task automatic test_reset_mid_miss();
        icache_hit_e = 1'b0;
        icache_hit_o = 1'b1;
        do_resteer(32'h0000_5000);
        cyc();
        cyc();
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL rmm_miss: got %b want 1", fetch_stall); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        icache_fill_done = 1'b1;
        #1;
        n_checks++; if ({fetch_stall, slot_valid, head_slot} !== {1'b1, 4'b0000, 2'd0}) begin n_fail++; $display("FAIL rmm_reset: got %b want 1000000", {fetch_stall, slot_valid, head_slot}); end
        cyc();
        icache_fill_done = 1'b0;
        #1;
        n_checks++; if ({fetch_stall, icache_req_e, icache_req_o} !== 3'b100) begin n_fail++; $display("FAIL rmm_fill_ignored: got %b want 100", {fetch_stall, icache_req_e, icache_req_o}); end
        // Reset during FLUSH
        do_resteer(32'h0000_6000);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        n_checks++; if ({fetch_stall, icache_req_e, icache_req_o} !== 3'b100) begin n_fail++; $display("FAIL rmf_idle: got %b want 100", {fetch_stall, icache_req_e, icache_req_o}); end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        resteer          = 1'b0;
        resteer_addr     = 32'h0000_0000;
        line_release     = 1'b0;
        icache_hit_e     = 1'b0;
        icache_hit_o     = 1'b0;
        icache_fill_done = 1'b0;
        test_reset();
        test_aligned_fetch();
        test_odd_start();
        test_wrap();
        test_a_hit_b_miss();
        test_a_miss_b_hit();
        test_full_release();
        test_resteer_priority();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
